interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
//  CPU-side end of the PIC interrupt path: raises INT, runs the INTA handshake, places the vector on the data bus.
//  Takes the winning level from the priority resolver; on the first INTA: freezes the request register,
//  clears the serviced IR line, sets its ISR bit. Handles the 8086 two-pulse sequence and AEOI.
// PARAMETERS
//  TIMEOUT_CYCLES  255  clk cycles allowed between INTA edges before abort; 0 disables watchdog
//  SPURIOUS_IR     7    level reported when INTA arrives with no valid request
// PORTS
//  clk             in   1  single clock; all state changes on posedge
//  rst_n           in   1  synchronous, active-low reset
//  inta_n          in   1  CPU interrupt acknowledge, active low, already synchronous to clk
//  int_req         in   1  priority resolver: unmasked request pending
//  highest_ir      in   3  priority resolver: winning level
//  vector_base     in   5  ICW2 T7..T3
//  aeoi            in   1  ICW4 auto-EOI enable
//  mode_8086       in   1  ICW4 uPM; 1=8086 two-pulse, 0=8080 CALL (PIC_CALL_MODE_EN only)
//  call_addr       in  11  {ICW2 A15..A8, ICW1 A7..A5} (PIC_CALL_MODE_EN only)
//  adi             in   1  ICW1 call interval, 1=4, 0=8 (PIC_CALL_MODE_EN only)
//  int_out         out  1  INT pin to CPU
//  freeze          out  1  hold request register during acknowledge
//  clear_ir_line   out  8  one-hot, 1-cycle pulse: clear serviced IR
//  set_isr         out  8  one-hot, 1-cycle pulse: set in-service bit
//  auto_eoi        out  8  one-hot, 1-cycle pulse: clear in-service bit (AEOI)
//  data_out        out  8  vector/CALL byte
//  data_oe         out  1  drive data_out onto bus
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, all outputs 0, captured level 0, watchdog 0. Applies mid-sequence;
//    no pulse completes after reset.
//  - inta_n registered once internally; fall = prev 1 & cur 0, rise = prev 0 & cur 1; prev resets to 1.
//  - IDLE: int_out <= int_req (1-cycle latency). On fall: capture lvl = int_req ? highest_ir : SPURIOUS_IR,
//    spur = ~int_req; freeze=1, int_out=0; next cycle clear_ir_line[lvl] and (if !spur) set_isr[lvl] pulse -> ACK1.
//  - ACK1 (8086): data_oe=0. Rise -> WAIT2.
//  - WAIT2: fall -> ACK2. ACK2: data_out={vector_base,lvl}, data_oe=1 while inta_n low.
//  - ACK2 rise: data_oe=0; if aeoi & !spur, auto_eoi[lvl] pulse; freeze=0 -> IDLE.
//    int_out re-evaluated starting the following cycle.
//  - Spurious: vector still driven with lvl=SPURIOUS_IR; no set_isr; no auto_eoi.
//  - int_req/highest_ir changes after capture are ignored until IDLE.
//  - Fall in same cycle as rise impossible (single input); consecutive edges each take one state step.
//  - Watchdog: counts in every non-IDLE state, reloads on each INTA edge. At TIMEOUT_CYCLES: data_oe=0, freeze=0,
//    -> IDLE, no auto_eoi; ISR bit stays set.
//  - Pulse outputs are exactly one cycle wide; one-hot decode of lvl only.
// CONFIGURATION
//  PIC_CALL_MODE_EN defined: mode_8086=0 selects three-pulse 8080 sequence:
//    ACK1 drives 8'hCD (data_oe=1); ACK2 drives adi ? {call_addr[2:0],lvl,2'b00} : {call_addr[2:1],lvl,3'b000};
//    ACK3 drives call_addr[10:3]; AEOI/release on ACK3 rise. States WAIT3/ACK3 added.
//  Not defined: mode_8086, call_addr, adi ignored; always 8086 sequence; no WAIT3/ACK3 logic.
// STRUCTURE
//  pic_pkg: ack state enum (IDLE, ACK1, WAIT2, ACK2, WAIT3, ACK3); CALL_OPCODE=8'hCD; IR_W=3; NUM_IR=8.
//  Sub-module inta_edge_detect: registered inta_n, fall/rise strobes.
//  FSM, watchdog counter, one-hot decode in top.
// TESTING
//  1. int_req=1, highest_ir=3, vector_base=5'h10, aeoi=0; two INTA pulses
//     -> int_out 1 then 0 at fall1; clear_ir_line=8'h08 and set_isr=8'h08 once; ACK2 data_out=8'h83, oe=1.
//  2. Same with aeoi=1 -> auto_eoi=8'h08 single pulse after ACK2 rise; freeze low same cycle.
//  3. int_req drops to 0 before fall1 -> set_isr stays 0; clear_ir_line=8'h80; ACK2 data_out={vector_base,3'd7}.
//  4. highest_ir changes 3->1 between pulses -> ACK2 still drives level 3.
//  5. Hold inta_n high after ACK1 for TIMEOUT_CYCLES -> freeze=0, IDLE, no auto_eoi; rst_n=0 during ACK2 -> all outputs 0 next cycle.
//  6. PIC_CALL_MODE_EN, mode_8086=0, adi=1, call_addr=11'h5A5, lvl 2 -> bytes 8'hCD, 8'hA8, 8'hB4 on pulses 1-3.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the PIC interrupt-acknowledge path.
//   ack_state_e  - acknowledge sequencer state (IDLE, ACK1, WAIT2, ACK2, WAIT3, ACK3)
//   CALL_OPCODE  - 8080 CALL opcode driven on the first INTA pulse in call mode
//   IR_W/NUM_IR  - interrupt level width and number of IR lines
//   ir_onehot()  - one-hot decode of an IR level
package pic_pkg;

  localparam int IR_W   = 3;
  localparam int NUM_IR = 8;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK1  = 3'd1,
    WAIT2 = 3'd2,
    ACK2  = 3'd3,
    WAIT3 = 3'd4,
    ACK3  = 3'd5
  } ack_state_e;

  function automatic logic [NUM_IR-1:0] ir_onehot(input logic [IR_W-1:0] lvl);
    logic [NUM_IR-1:0] oh;
    oh      = '0;
    oh[lvl] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// inta_edge_detect: registers inta_n once and produces single-cycle edge strobes.
//   clk, rst_n  - clock, synchronous active-low reset
//   inta_n      - CPU interrupt acknowledge (already synchronous to clk)
//   inta_fall   - previous sample 1, current 0
//   inta_rise   - previous sample 0, current 1
// The previous sample resets to 1 (inactive), so a low inta_n right after
// reset is seen as a falling edge.
module inta_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic inta_fall,
  output logic inta_rise
);

  logic inta_q;
  logic inta_d;

  always_comb begin
    inta_d = inta_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inta_q <= 1'b1;
    end else begin
      inta_q <= inta_d;
    end
  end

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: CPU-side end of the PIC interrupt path. Raises INT,
// runs the INTA handshake and places the vector (or CALL bytes) on the data bus.
//
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   inta_n         - CPU interrupt acknowledge, active low, synchronous to clk
//   int_req        - resolver: unmasked request pending
//   highest_ir     - resolver: winning level
//   vector_base    - ICW2 T7..T3
//   aeoi           - auto-EOI enable
//   mode_8086      - 1 = 8086 two-pulse, 0 = 8080 CALL (call mode build only)
//   call_addr      - {ICW2 A15..A8, ICW1 A7..A5} (call mode build only)
//   adi            - call interval, 1 = 4, 0 = 8 (call mode build only)
//   int_out        - INT pin to CPU
//   freeze         - hold request register during acknowledge
//   clear_ir_line  - one-hot 1-cycle pulse: clear serviced IR
//   set_isr        - one-hot 1-cycle pulse: set in-service bit
//   auto_eoi       - one-hot 1-cycle pulse: clear in-service bit
//   data_out       - vector / CALL byte (0 while not driven)
//   data_oe        - drive data_out onto the bus
//   dbg_state      - current acknowledge state
//
// Handshake: every INTA falling edge starts a bus cycle and every rising edge
// ends one; each edge advances the FSM by exactly one step. All outputs are
// registered, so they change one clock after the edge is seen.
//
// Build option: define PIC_CALL_MODE_EN to add the three-pulse 8080 CALL
// sequence (WAIT3/ACK3). Without it the 8086 sequence is always used.
//
// Watchdog: counts cycles in every non-IDLE state and reloads on each INTA
// edge; reaching TIMEOUT_CYCLES aborts back to IDLE without auto-EOI (the ISR
// bit stays set). TIMEOUT_CYCLES = 0 disables it.
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SPURIOUS_IR    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inta_n,
  input  logic              int_req,
  input  logic [IR_W-1:0]   highest_ir,
  input  logic [4:0]        vector_base,
  input  logic              aeoi,
  input  logic              mode_8086,
  input  logic [10:0]       call_addr,
  input  logic              adi,
  output logic              int_out,
  output logic              freeze,
  output logic [NUM_IR-1:0] clear_ir_line,
  output logic [NUM_IR-1:0] set_isr,
  output logic [NUM_IR-1:0] auto_eoi,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output ack_state_e        dbg_state
);

  localparam int unsigned     WD_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [IR_W-1:0] SPUR_LVL = IR_W'(SPURIOUS_IR);

  logic inta_fall;
  logic inta_rise;

  inta_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .inta_n    (inta_n),
    .inta_fall (inta_fall),
    .inta_rise (inta_rise)
  );

  ack_state_e        state_q, state_d;
  logic [IR_W-1:0]   lvl_q, lvl_d;
  logic              spur_q, spur_d;
  logic              int_out_q, int_out_d;
  logic              freeze_q, freeze_d;
  logic [NUM_IR-1:0] clear_ir_q, clear_ir_d;
  logic [NUM_IR-1:0] set_isr_q, set_isr_d;
  logic [NUM_IR-1:0] auto_eoi_q, auto_eoi_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [IR_W-1:0]   cap_lvl;
  logic              done;
  logic              timeout;

`ifdef PIC_CALL_MODE_EN
  // Sequence type is latched on the first INTA so a mode change mid-sequence
  // cannot mix 8086 and 8080 bus cycles.
  logic call_q, call_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode_8086, call_addr, adi};
`endif

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    spur_d     = spur_q;
    int_out_d  = int_out_q;
    freeze_d   = freeze_q;
    clear_ir_d = '0;
    set_isr_d  = '0;
    auto_eoi_d = '0;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    wd_d       = '0;
    done       = 1'b0;
    timeout    = 1'b0;
    cap_lvl    = int_req ? highest_ir : SPUR_LVL;
`ifdef PIC_CALL_MODE_EN
    call_d     = call_q;
`endif

    // An INTA edge reloads the watchdog (wd_d stays 0); an edge arriving in
    // the terminal cycle wins over the timeout.
    if (WD_EN && (state_q != IDLE) && !(inta_fall || inta_rise)) begin
      if (wd_q == WD_MAX) begin
        timeout = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        int_out_d = int_req;
        if (inta_fall) begin
          state_d    = ACK1;
          lvl_d      = cap_lvl;
          spur_d     = ~int_req;
          freeze_d   = 1'b1;
          int_out_d  = 1'b0;
          clear_ir_d = ir_onehot(cap_lvl);
          set_isr_d  = int_req ? ir_onehot(cap_lvl) : '0;
`ifdef PIC_CALL_MODE_EN
          call_d = ~mode_8086;
          if (!mode_8086) begin
            data_out_d = CALL_OPCODE;
            data_oe_d  = 1'b1;
          end
`endif
        end
      end

      ACK1: begin
        if (inta_rise) begin
          state_d    = WAIT2;
          data_oe_d  = 1'b0;
          data_out_d = '0;
        end
      end

      WAIT2: begin
        if (inta_fall) begin
          state_d    = ACK2;
          data_oe_d  = 1'b1;
          data_out_d = {vector_base, lvl_q};
`ifdef PIC_CALL_MODE_EN
          if (call_q) begin
            data_out_d = adi ? {call_addr[2:0], lvl_q, 2'b00}
                             : {call_addr[2:1], lvl_q, 3'b000};
          end
`endif
        end
      end

      ACK2: begin
        if (inta_rise) begin
`ifdef PIC_CALL_MODE_EN
          if (call_q) begin
            state_d    = WAIT3;
            data_oe_d  = 1'b0;
            data_out_d = '0;
          end else begin
            done = 1'b1;
          end
`else
          done = 1'b1;
`endif
        end
      end

`ifdef PIC_CALL_MODE_EN
      WAIT3: begin
        if (inta_fall) begin
          state_d    = ACK3;
          data_oe_d  = 1'b1;
          data_out_d = call_addr[10:3];
        end
      end

      ACK3: begin
        if (inta_rise) begin
          done = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // Normal end of the last bus cycle; int_out stays low this cycle and is
    // re-evaluated from IDLE on the next.
    if (done) begin
      state_d    = IDLE;
      freeze_d   = 1'b0;
      data_oe_d  = 1'b0;
      data_out_d = '0;
      if (aeoi && !spur_q) begin
        auto_eoi_d = ir_onehot(lvl_q);
      end
    end

    if (timeout) begin
      state_d    = IDLE;
      freeze_d   = 1'b0;
      data_oe_d  = 1'b0;
      data_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      spur_q     <= 1'b0;
      int_out_q  <= 1'b0;
      freeze_q   <= 1'b0;
      clear_ir_q <= '0;
      set_isr_q  <= '0;
      auto_eoi_q <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      spur_q     <= spur_d;
      int_out_q  <= int_out_d;
      freeze_q   <= freeze_d;
      clear_ir_q <= clear_ir_d;
      set_isr_q  <= set_isr_d;
      auto_eoi_q <= auto_eoi_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      wd_q       <= wd_d;
    end
  end

`ifdef PIC_CALL_MODE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      call_q <= 1'b0;
    end else begin
      call_q <= call_d;
    end
  end
`endif

  assign int_out       = int_out_q;
  assign freeze        = freeze_q;
  assign clear_ir_line = clear_ir_q;
  assign set_isr       = set_isr_q;
  assign auto_eoi      = auto_eoi_q;
  assign data_out      = data_out_q;
  assign data_oe       = data_oe_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Testbench for interrupt_ack_sequencer: directed scenarios plus randomized
// acknowledge sequences. Expected pulses and bus bytes are queued when a
// sequence is issued and popped by an independent monitor when the DUT
// presents them.
module tb_interrupt_ack_sequencer;
  import pic_pkg::*;

  localparam int         TIMEOUT = 255;
  localparam logic [2:0] SPUR    = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inta_n;
  logic       int_req;
  logic [2:0] highest_ir;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       mode_8086;
  logic [10:0] call_addr;
  logic       adi;
  logic       int_out;
  logic       freeze;
  logic [7:0] clear_ir_line;
  logic [7:0] set_isr;
  logic [7:0] auto_eoi;
  logic [7:0] data_out;
  logic       data_oe;
  ack_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_clear_q[$];
  logic [7:0] exp_set_q[$];
  logic [7:0] exp_eoi_q[$];
  logic [7:0] exp_byte_q[$];

  interrupt_ack_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .SPURIOUS_IR(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inta_n        (inta_n),
    .int_req       (int_req),
    .highest_ir    (highest_ir),
    .vector_base   (vector_base),
    .aeoi          (aeoi),
    .mode_8086     (mode_8086),
    .call_addr     (call_addr),
    .adi           (adi),
    .int_out       (int_out),
    .freeze        (freeze),
    .clear_ir_line (clear_ir_line),
    .set_isr       (set_isr),
    .auto_eoi      (auto_eoi),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] l);
    return 8'd1 << l;
  endfunction

  // monitor: pops one expectation per presented pulse / bus-cycle start
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear_ir_line != 8'd0) begin
        if (exp_clear_q.size() == 0) check("clear_unexpected", clear_ir_line, 0);
        else check("clear_ir_line", clear_ir_line, exp_clear_q.pop_front());
      end
      if (set_isr != 8'd0) begin
        if (exp_set_q.size() == 0) check("set_isr_unexpected", set_isr, 0);
        else check("set_isr", set_isr, exp_set_q.pop_front());
      end
      if (auto_eoi != 8'd0) begin
        if (exp_eoi_q.size() == 0) check("auto_eoi_unexpected", auto_eoi, 0);
        else check("auto_eoi", auto_eoi, exp_eoi_q.pop_front());
      end
      if (data_oe && !prev_oe) begin
        if (exp_byte_q.size() == 0) check("byte_unexpected", {24'd0, data_out}, 32'h100);
        else check("data_out", data_out, exp_byte_q.pop_front());
      end
    end
    prev_oe = data_oe;
  end

  // Reference: level = request ? winner : spurious; ISR/AEOI only for real
  // requests; 8086 vector = {base, level}; 8080 CALL = opcode, low addr, high addr.
  task automatic push_expect(input bit req, input logic [2:0] hir, input logic [4:0] vb,
                             input bit ae, input bit call, input bit completes);
    logic [2:0] lvl;
    logic [7:0] b2;
    lvl = req ? hir : SPUR;
    exp_clear_q.push_back(oh(lvl));
    if (req) exp_set_q.push_back(oh(lvl));
    if (call) begin
      b2 = adi ? {call_addr[2:0], lvl, 2'b00} : {call_addr[2:1], lvl, 3'b000};
      exp_byte_q.push_back(8'hCD);
      exp_byte_q.push_back(b2);
      exp_byte_q.push_back(call_addr[10:3]);
    end else begin
      exp_byte_q.push_back({vb, lvl});
    end
    if (completes && ae && req) exp_eoi_q.push_back(oh(lvl));
  endtask

  // driver: one full acknowledge sequence
  task automatic run_seq(input bit req_idle, input bit req_fall, input logic [2:0] hir,
                         input logic [2:0] hir2, input logic [4:0] vb, input bit ae,
                         input bit call, input int gap);
    int npulse;
    int_req = req_idle; highest_ir = hir; vector_base = vb; aeoi = ae; mode_8086 = ~call;
    tick(); tick();
    check("int_out_idle", int_out, req_idle);
    int_req = req_fall;
    push_expect(req_fall, hir, vb, ae, call, 1'b1);
    npulse = call ? 3 : 2;
    for (int p = 0; p < npulse; p++) begin
      inta_n = 1'b0;
      tick();
      if (p == 0) begin
        check("int_out_at_fall1", int_out, 0);
        check("freeze_at_fall1", freeze, 1);
        highest_ir = hir2;
        int_req    = 1'($urandom_range(0, 1));
      end
      repeat (gap) tick();
      inta_n = 1'b1;
      tick();
      if (p != npulse - 1) repeat (gap) tick();
    end
    check("freeze_release", freeze, 0);
    check("oe_release", data_oe, 0);
  endtask

  // driver: first pulse only, then INTA stays high until the watchdog fires
  task automatic run_timeout();
    int k;
    int_req = 1'b1; highest_ir = 3'd5; vector_base = 5'h0A; aeoi = 1'b1; mode_8086 = 1'b1;
    tick(); tick();
    push_expect(1'b1, 3'd5, 5'h0A, 1'b1, 1'b0, 1'b0);
    exp_byte_q.delete();
    inta_n = 1'b0; tick(); tick();
    inta_n = 1'b1; tick();
    k = 0;
    while (freeze && k < TIMEOUT + 50) begin
      tick();
      k++;
    end
    check("timeout_freeze", freeze, 0);
    check("timeout_state", dbg_state, IDLE);
    check("timeout_window", (k >= TIMEOUT - 1 && k <= TIMEOUT + 2) ? 1 : 0, 1);
    check("timeout_oe", data_oe, 0);
  endtask

  // driver: reset asserted while the vector is on the bus
  task automatic run_reset_mid();
    int_req = 1'b1; highest_ir = 3'd6; vector_base = 5'h1F; aeoi = 1'b1; mode_8086 = 1'b1;
    tick(); tick();
    push_expect(1'b1, 3'd6, 5'h1F, 1'b1, 1'b0, 1'b0);
    inta_n = 1'b0; tick(); tick();
    inta_n = 1'b1; tick(); tick();
    inta_n = 1'b0; tick(); tick();
    check("reset_pre_oe", data_oe, 1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_int_out", int_out, 0);
    check("rst_mid_freeze", freeze, 0);
    check("rst_mid_oe", data_oe, 0);
    check("rst_mid_data", data_out, 0);
    check("rst_mid_pulses", {clear_ir_line, set_isr, auto_eoi}, 0);
    check("rst_mid_state", dbg_state, IDLE);
    inta_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rst_after_eoi", auto_eoi, 0);
  endtask

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; int_req = 1'b0; highest_ir = 3'd0; vector_base = 5'd0;
    aeoi = 1'b0; mode_8086 = 1'b1; call_addr = 11'h5A5; adi = 1'b1;
    repeat (3) tick();
    check("rst_int_out", int_out, 0);
    check("rst_freeze", freeze, 0);
    check("rst_oe", data_oe, 0);
    check("rst_data", data_out, 0);
    check("rst_pulses", {clear_ir_line, set_isr, auto_eoi}, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    tick();

    // directed: basic, AEOI, spurious, level change between pulses
    run_seq(1'b1, 1'b1, 3'd3, 3'd3, 5'h10, 1'b0, 1'b0, 1);
    run_seq(1'b1, 1'b1, 3'd3, 3'd3, 5'h10, 1'b1, 1'b0, 2);
    run_seq(1'b1, 1'b0, 3'd3, 3'd3, 5'h10, 1'b1, 1'b0, 1);
    run_seq(1'b1, 1'b1, 3'd3, 3'd1, 5'h10, 1'b1, 1'b0, 3);
    run_seq(1'b1, 1'b1, 3'd0, 3'd7, 5'h01, 1'b1, 1'b0, 1);

    run_timeout();
    run_reset_mid();

`ifdef PIC_CALL_MODE_EN
    call_addr = 11'h5A5; adi = 1'b1;
    run_seq(1'b1, 1'b1, 3'd2, 3'd2, 5'h00, 1'b1, 1'b1, 1);
    call_addr = 11'h3C7; adi = 1'b0;
    run_seq(1'b1, 1'b1, 3'd6, 3'd0, 5'h00, 1'b1, 1'b1, 2);
`endif

    for (int i = 0; i < 25; i++) begin
      logic r;
      logic c;
      r = ($urandom_range(0, 3) != 0);
      c = 1'b0;
`ifdef PIC_CALL_MODE_EN
      c         = 1'($urandom_range(0, 1));
      call_addr = 11'($urandom_range(0, 2047));
      adi       = 1'($urandom_range(0, 1));
`endif
      run_seq(1'($urandom_range(0, 1)), r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), c, $urandom_range(0, 4));
    end

    repeat (5) tick();
    check("pending_clear", exp_clear_q.size(), 0);
    check("pending_set", exp_set_q.size(), 0);
    check("pending_eoi", exp_eoi_q.size(), 0);
    check("pending_byte", exp_byte_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
